// File: rtl/onehot_decoder_stream.sv
// Registered index-to-one-hot decoder behind a valid/ready handshake. Each word is
// held for at least HOLD_CYCLES cycles. Define ONEHOT_DEC_ERR_CNT_EN to add err_cnt.
module onehot_decoder_stream #(
    parameter int IDX_W       = 2,
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_OUT-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
`ifdef ONEHOT_DEC_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t           state, state_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [N_OUT-1:0] out_nx, dec;
    logic             ov_nx, err_nx;
    logic             rdy_en, bad, completion, accept;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
        assign dec[gi] = (in == IDX_W'(gi));
    end

    assign bad        = (32'(in) >= 32'(N_OUT));
    assign completion = (state == HOLD) && out_ready && (cnt == 8'd0);
    // rdy_en keeps in_ready low until the first edge after reset release
    assign in_ready   = rdy_en && ((state == IDLE) || completion);
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        out_nx   = out;
        ov_nx    = out_valid;
        err_nx   = err;
        if (accept) begin
            out_nx   = bad ? '0 : dec;
            err_nx   = bad;
            ov_nx    = 1'b1;
            cnt_nx   = HOLD_INIT;
            state_nx = HOLD;
        end else if (completion) begin
            out_nx   = '0;
            err_nx   = 1'b0;
            ov_nx    = 1'b0;
            state_nx = IDLE;
        end else if (state == HOLD && cnt != 8'd0) begin
            cnt_nx = cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out       <= out_nx;
            out_valid <= ov_nx;
            err       <= err_nx;
            rdy_en    <= 1'b1;
        end
    end

`ifdef ONEHOT_DEC_ERR_CNT_EN
    // saturating count of out-of-range indices, bumped on the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (accept && bad && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed bench for onehot_decoder_stream: four instances cover the default,
// HOLD_CYCLES=3, HOLD_CYCLES=4 and N_OUT=3 configurations.
module tb_onehot_decoder_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // a: defaults, b: HOLD_CYCLES=3, c: HOLD_CYCLES=4, e: N_OUT=3
    logic [1:0] a_in = '0, b_in = '0, c_in = '0, e_in = '0;
    logic a_iv = 0, b_iv = 0, c_iv = 0, e_iv = 0;
    logic a_or = 1, b_or = 1, c_or = 1, e_or = 1;
    logic a_ir, b_ir, c_ir, e_ir;
    logic a_ov, b_ov, c_ov, e_ov;
    logic a_err, b_err, c_err, e_err;
    logic [3:0] a_out, b_out, c_out;
    logic [2:0] e_out;
`ifdef ONEHOT_DEC_ERR_CNT_EN
    logic [7:0] a_ec, b_ec, c_ec, e_ec;
`endif

    onehot_decoder_stream u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .in_valid(a_iv), .in_ready(a_ir),
        .out(a_out), .out_valid(a_ov), .out_ready(a_or), .err(a_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
        , .err_cnt(a_ec)
`endif
    );

    onehot_decoder_stream #(.HOLD_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .in_valid(b_iv), .in_ready(b_ir),
        .out(b_out), .out_valid(b_ov), .out_ready(b_or), .err(b_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
        , .err_cnt(b_ec)
`endif
    );

    onehot_decoder_stream #(.HOLD_CYCLES(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in(c_in), .in_valid(c_iv), .in_ready(c_ir),
        .out(c_out), .out_valid(c_ov), .out_ready(c_or), .err(c_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
        , .err_cnt(c_ec)
`endif
    );

    onehot_decoder_stream #(.N_OUT(3)) u_e (
        .clk(clk), .rst_n(rst_n), .in(e_in), .in_valid(e_iv), .in_ready(e_ir),
        .out(e_out), .out_valid(e_ov), .out_ready(e_or), .err(e_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
        , .err_cnt(e_ec)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // held in reset
        #2;
        chk("rst_out", 32'(a_out), 0);
        chk("rst_ov", 32'(a_ov), 0);
        chk("rst_err", 32'(a_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_ir", 32'(a_ir), 1);

        // idle for 10 cycles
        for (int i = 0; i < 10; i++) tick();
        chk("idle_out", 32'(a_out), 0);
        chk("idle_ov", 32'(a_ov), 0);
        chk("idle_err", 32'(a_err), 0);
        chk("idle_ir", 32'(a_ir), 1);

        // back-to-back 0..3 at one word per cycle
        a_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in = 2'(i);
            tick();
            chk($sformatf("b2b_out%0d", i), 32'(a_out), 32'(1 << i));
            chk($sformatf("b2b_ov%0d", i), 32'(a_ov), 1);
            chk($sformatf("b2b_ir%0d", i), 32'(a_ir), 1);
            chk($sformatf("b2b_err%0d", i), 32'(a_err), 0);
        end
        a_iv = 1'b0;
        tick();
        chk("b2b_end_out", 32'(a_out), 0);
        chk("b2b_end_ov", 32'(a_ov), 0);

        // consumer stall: in=1 held, in=3 waits for out_ready
        a_or = 1'b0;
        a_in = 2'd1;
        a_iv = 1'b1;
        tick();
        a_in = 2'd3;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_out%0d", i), 32'(a_out), 32'h2);
            chk($sformatf("stall_ir%0d", i), 32'(a_ir), 0);
            tick();
        end
        chk("stall_keep", 32'(a_out), 32'h2);
        a_or = 1'b1;
        #1;
        chk("stall_ir_rel", 32'(a_ir), 1);
        tick();
        a_iv = 1'b0;
        chk("stall_next", 32'(a_out), 32'h8);
        chk("stall_next_ov", 32'(a_ov), 1);
        tick();
        chk("stall_idle_ov", 32'(a_ov), 0);
        chk("stall_idle_out", 32'(a_out), 0);

        // HOLD_CYCLES=3: valid exactly three cycles, ready only on the last
        b_in = 2'd2;
        b_iv = 1'b1;
        tick();
        b_iv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("h3_out%0d", i), 32'(b_out), 32'h4);
            chk($sformatf("h3_ov%0d", i), 32'(b_ov), 1);
            chk($sformatf("h3_ir%0d", i), 32'(b_ir), (i == 2) ? 1 : 0);
            tick();
        end
        chk("h3_done_ov", 32'(b_ov), 0);
        chk("h3_done_out", 32'(b_out), 0);

        // N_OUT=3: index 3 is out of range
        e_in = 2'd3;
        e_iv = 1'b1;
        tick();
        chk("oor_out", 32'(e_out), 0);
        chk("oor_ov", 32'(e_ov), 1);
        chk("oor_err", 32'(e_err), 1);
`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("oor_cnt1", 32'(e_ec), 1);
`endif
        for (int i = 0; i < 299; i++) tick();
        chk("oor_err_300", 32'(e_err), 1);
`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("oor_cnt_sat", 32'(e_ec), 255);
`endif
        e_in = 2'd1;
        tick();
        chk("inr_out", 32'(e_out), 32'h2);
        chk("inr_err", 32'(e_err), 0);
        e_iv = 1'b0;
        tick();
        chk("e_idle_ov", 32'(e_ov), 0);
        chk("e_idle_err", 32'(e_err), 0);

        // HOLD_CYCLES=4: async reset in the middle of a hold
        c_in = 2'd3;
        c_iv = 1'b1;
        tick();
        c_iv = 1'b0;
        chk("h4_out", 32'(c_out), 32'h8);
        tick();
        chk("h4_hold", 32'(c_out), 32'h8);
        chk("h4_ir", 32'(c_ir), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(c_out), 0);
        chk("arst_ov", 32'(c_ov), 0);
        tick();
        rst_n = 1'b1;
        tick();
        c_in = 2'd2;
        c_iv = 1'b1;
        chk("arst_rel_ir", 32'(c_ir), 1);
        tick();
        c_iv = 1'b0;
        chk("arst_next_out", 32'(c_out), 32'h4);
        chk("arst_next_ov", 32'(c_ov), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
